// File: rtl/seg7_coord_driver_pkg.sv
// Shared constants for the coordinate seven-segment driver: glyphs, FSM states and MODE encodings.
// Segment vectors are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg7_coord_driver_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StConv = 1'b1
  } state_e;

  typedef enum logic {
    ModeHex = 1'b0,
    ModeDec = 1'b1
  } mode_e;

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = ~7'h40;

  function automatic logic [6:0] seg_glyph(input logic [3:0] value);
    logic [6:0] lit;
    unique case (value)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      4'hF: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational nibble to active-low seven-segment glyph (0-9, A, b, C, d, E, F).
module seg7_digit
  import seg7_coord_driver_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_glyph(digit_i);

endmodule

// File: rtl/seg7_coord_driver.sv
// Multi-channel coordinate display driver: hex (1 cycle) or decimal via double dabble (W cycles).
// Define SEG7_LZ_BLANK_EN to blank leading zero digits.
module seg7_coord_driver
  import seg7_coord_driver_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned W     = 12,
  parameter int unsigned N_DIG = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      LOAD,
  input  logic                      MODE,
  input  logic [N_CH*W-1:0]         COORD,
  output logic                      READY,
  output logic                      DONE,
  output logic [N_CH-1:0]           OVF,
  output logic [N_CH*N_DIG*7-1:0]   SEG
);

  localparam int unsigned CntW = $clog2(W + 1);
  localparam int unsigned BcdW = 4 * N_DIG;

  state_e                            state_q, state_d;
  mode_e                             mode_q, mode_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [N_CH-1:0][W-1:0]            shadow_q, shadow_d;
  logic [N_CH-1:0][BcdW-1:0]         bcd_q, bcd_d, bcd_adj, bcd_step;
  logic [N_CH-1:0]                   ovf_acc_q, ovf_acc_d, ovf_step, ovf_now;
  logic [N_CH-1:0][BcdW-1:0]         hex_ext;
  logic [N_CH-1:0][N_DIG-1:0][3:0]   disp_dig;
  logic [N_CH-1:0][N_DIG-1:0][6:0]   glyph, seg_new;
  logic [N_CH-1:0][N_DIG-1:0]        blank;
  logic [N_CH*N_DIG*7-1:0]           seg_q;
  logic [N_CH-1:0]                   ovf_q;
  logic                              done_q;
  logic                              update;

  // One double-dabble step per channel; a bit leaving the top digit marks overflow.
  always_comb begin
    bcd_adj  = '0;
    bcd_step = '0;
    ovf_step = '0;
    hex_ext  = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int d = 0; d < N_DIG; d++) begin
        bcd_adj[c][4*d +: 4] = (bcd_q[c][4*d +: 4] >= 4'd5) ? bcd_q[c][4*d +: 4] + 4'd3
                                                            : bcd_q[c][4*d +: 4];
      end
      ovf_step[c] = ovf_acc_q[c] | bcd_adj[c][BcdW-1];
      bcd_step[c] = {bcd_adj[c][BcdW-2:0], shadow_q[c][W-1]};
      hex_ext[c]  = BcdW'(shadow_q[c]);
    end
  end

  assign ovf_now = (mode_q == ModeDec) ? ovf_step : '0;

  always_comb begin
    disp_dig = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int d = 0; d < N_DIG; d++) begin
        disp_dig[c][d] = (mode_q == ModeDec) ? bcd_step[c][4*d +: 4] : hex_ext[c][4*d +: 4];
      end
    end
  end

  for (genvar gc = 0; gc < N_CH; gc++) begin : g_ch
    for (genvar gd = 0; gd < N_DIG; gd++) begin : g_dig
      seg7_digit u_digit (
        .digit_i (disp_dig[gc][gd]),
        .seg_o   (glyph[gc][gd])
      );
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic lz_run;

  // Walk down from the top digit; stays set while every digit seen so far is zero.
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      lz_run = 1'b1;
      for (int d = N_DIG - 1; d > 0; d--) begin
        lz_run      = lz_run & (disp_dig[c][d] == 4'd0);
        blank[c][d] = lz_run;
      end
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    seg_new = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int d = 0; d < N_DIG; d++) begin
        if (ovf_now[c]) begin
          seg_new[c][d] = SegDash;
        end else if (blank[c][d]) begin
          seg_new[c][d] = SegBlank;
        end else begin
          seg_new[c][d] = glyph[c][d];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    bcd_d     = bcd_q;
    ovf_acc_d = ovf_acc_q;
    update    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (LOAD) begin
          shadow_d  = COORD;
          mode_d    = mode_e'(MODE);
          bcd_d     = '0;
          ovf_acc_d = '0;
          cnt_d     = '0;
          state_d   = StConv;
        end
      end
      StConv: begin
        if (mode_q == ModeHex) begin
          update  = 1'b1;
          state_d = StIdle;
        end else begin
          bcd_d     = bcd_step;
          ovf_acc_d = ovf_step;
          for (int c = 0; c < N_CH; c++) begin
            shadow_d[c] = shadow_q[c] << 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(W - 1)) begin
            update  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      mode_q    <= ModeHex;
      cnt_q     <= '0;
      shadow_q  <= '0;
      bcd_q     <= '0;
      ovf_acc_q <= '0;
      seg_q     <= '1;
      ovf_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      bcd_q     <= bcd_d;
      ovf_acc_q <= ovf_acc_d;
      done_q    <= update;
      if (update) begin
        seg_q <= seg_new;
        ovf_q <= ovf_now;
      end
    end
  end

  assign READY = (state_q == StIdle);
  assign DONE  = done_q;
  assign OVF   = ovf_q;
  assign SEG   = seg_q;

endmodule

// File: tb/tb_seg7_coord_driver.sv
// Self-checking bench for seg7_coord_driver: a 4-digit and a 3-digit instance share stimulus.
module tb_seg7_coord_driver;

  logic        CLK, RST, LOAD, MODE;
  logic [23:0] COORD;
  logic        ready, done, ready3, done3;
  logic [1:0]  ovf, ovf3;
  logic [55:0] seg;
  logic [41:0] seg3;

  int checks   = 0;
  int failures = 0;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LzBlank = 1'b1;
`else
  localparam bit LzBlank = 1'b0;
`endif

  seg7_coord_driver #(.N_CH(2), .W(12), .N_DIG(4)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .MODE(MODE), .COORD(COORD),
    .READY(ready), .DONE(done), .OVF(ovf), .SEG(seg)
  );

  seg7_coord_driver #(.N_CH(2), .W(12), .N_DIG(3)) dut3 (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .MODE(MODE), .COORD(COORD),
    .READY(ready3), .DONE(done3), .OVF(ovf3), .SEG(seg3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] c0;
    logic [11:0] c1;
    bit          mode;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int unsigned v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit model_ovf(input int unsigned v, input bit m, input int ndig);
    int unsigned lim = 1;
    for (int i = 0; i < ndig; i++) lim = lim * 10;
    return m && (v >= lim);
  endfunction

  // Digits from plain division: base 10 or 16, leading zeros are digits above value < base^d.
  function automatic logic [27:0] model_seg(input int unsigned v, input bit m, input int ndig);
    logic [27:0] r = '1;
    int unsigned base = m ? 10 : 16;
    int unsigned p = 1;
    bit o = model_ovf(v, m, ndig);
    for (int d = 0; d < ndig; d++) begin
      if (o) r[7*d +: 7] = 7'b0111111;
      else if (LzBlank && d > 0 && v < p) r[7*d +: 7] = 7'b1111111;
      else r[7*d +: 7] = ref_glyph((v / p) % base);
      p = p * base;
    end
    return r;
  endfunction

  task automatic start_conv(input logic [11:0] c0, input logic [11:0] c1, input bit m);
    @(negedge CLK);
    LOAD  = 1'b1;
    COORD = {c1, c0};
    MODE  = m;
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic compare_all(input logic [11:0] c0, input logic [11:0] c1, input bit m,
                             input string tag);
    logic [27:0] e0, e1, f0, f1;
    e0 = model_seg(c0, m, 4);
    e1 = model_seg(c1, m, 4);
    f0 = model_seg(c0, m, 3);
    f1 = model_seg(c1, m, 3);
    check({tag, "_seg"}, seg, {e1, e0});
    check({tag, "_ovf"}, ovf, {model_ovf(c1, m, 4), model_ovf(c0, m, 4)});
    check({tag, "_seg3"}, seg3, {f1[20:0], f0[20:0]});
    check({tag, "_ovf3"}, ovf3, {model_ovf(c1, m, 3), model_ovf(c0, m, 3)});
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    int ndone;
    logic [11:0] r0, r1;
    bit rm;

    vecs[0] = '{12'hA5F, 12'h010, 1'b0, 1};
    vecs[1] = '{12'd4095, 12'd0, 1'b1, 12};
    vecs[2] = '{12'd1000, 12'd999, 1'b1, 12};
    vecs[3] = '{12'd999, 12'd1000, 1'b1, 12};
    vecs[4] = '{12'd0, 12'd0, 1'b1, 12};
    vecs[5] = '{12'h000, 12'h000, 1'b0, 1};
    vecs[6] = '{12'hFFF, 12'h100, 1'b0, 1};
    vecs[7] = '{12'd9, 12'd10, 1'b1, 12};
    vecs[8] = '{12'd100, 12'h00F, 1'b1, 12};

    RST = 1'b1; LOAD = 1'b0; MODE = 1'b0; COORD = '0;
    #1;
    check("rst_seg", seg, {56{1'b1}});
    check("rst_seg3", seg3, {42{1'b1}});
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 2'b00);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      start_conv(vecs[i].c0, vecs[i].c1, vecs[i].mode);
      check($sformatf("vec%0d_busy", i), ready, 1'b0);
      wait_done(lat);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_done3", i), done3, 1'b1);
      compare_all(vecs[i].c0, vecs[i].c1, vecs[i].mode, $sformatf("vec%0d", i));
      if (i == 0) begin
        check("hex_ch0_d0", seg[6:0], 7'b0001110);
        check("hex_ch0_d1", seg[13:7], 7'b0010010);
        check("hex_ch0_d2", seg[20:14], 7'b0001000);
        check("hex_ch1_d0", seg[34:28], 7'b1000000);
        check("hex_ch1_d1", seg[41:35], 7'b1111001);
      end
      if (i == 1) begin
        check("dec_d0", seg[6:0], 7'b0010010);
        check("dec_d1", seg[13:7], 7'b0010000);
        check("dec_d2", seg[20:14], 7'b1000000);
        check("dec_d3", seg[27:21], 7'b0011001);
        check("dec_ovf0", ovf[0], 1'b0);
      end
      if (i == 2) begin
        check("ovf3_dash", seg3[20:0], {3{7'b0111111}});
        check("ovf3_flag", ovf3[0], 1'b1);
      end
      if (i == 3) begin
        check("n999_digits", seg3[20:0], {3{7'b0010000}});
        check("n999_flag", ovf3[0], 1'b0);
      end
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d_pulse", i), {done, ready}, 2'b01);
    end

    // LOAD and COORD churn during CONV must not disturb the captured value.
    start_conv(12'd2468, 12'd1357, 1'b1);
    lat = 0;
    do begin
      @(negedge CLK);
      LOAD  = 1'b1;
      COORD = 24'($urandom);
      MODE  = 1'($urandom);
      @(posedge CLK);
      #1;
      lat++;
    end while (!done && lat < 40);
    check("churn_lat", lat, 12);
    compare_all(12'd2468, 12'd1357, 1'b1, "churn");
    // LOAD held in the DONE cycle starts a new conversion.
    LOAD = 1'b1; COORD = {12'h0C3, 12'hB2E}; MODE = 1'b0;
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
    check("done_cycle_accept", ready, 1'b0);
    wait_done(lat);
    check("done_cycle_lat", lat, 1);
    compare_all(12'hB2E, 12'h0C3, 1'b0, "done_cycle");

    // Reset in the fifth CONV cycle aborts the conversion.
    start_conv(12'd1234, 12'd777, 1'b1);
    repeat (4) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("abort_seg", seg, {56{1'b1}});
    check("abort_seg3", seg3, {42{1'b1}});
    check("abort_ready", ready, 1'b1);
    check("abort_done_ovf", {done, ovf}, 3'b000);
    @(negedge CLK);
    RST = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (done || done3) ndone++;
    end
    check("abort_no_done", ndone, 0);

    for (int i = 0; i < 30; i++) begin
      r0 = 12'($urandom_range(0, 4095));
      r1 = 12'($urandom_range(0, 4095));
      rm = 1'($urandom_range(0, 1));
      start_conv(r0, r1, rm);
      wait_done(lat);
      check($sformatf("rnd%0d_lat", i), lat, rm ? 12 : 1);
      compare_all(r0, r1, rm, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_coord_driver.md
SEG7_COORD_DRIVER -- requirements
Module: seg7_coord_driver

Interface
REQ-001 Parameter N_CH, default 2, number of coordinate channels.
REQ-002 Parameter W, default 12, coordinate width in bits per channel.
REQ-003 Parameter N_DIG, default 4, displayed digits per channel; SHALL be >= ceil(W/4).
REQ-004 CLK  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 LOAD  in  1  request to capture COORD/MODE; accepted only while READY=1.
REQ-007 MODE  in  1  0 = hexadecimal display, 1 = decimal display.
REQ-008 COORD  in  N_CH*W  channel c at COORD[c*W +: W], unsigned.
REQ-009 READY  out  1  high when idle and able to accept LOAD.
REQ-010 DONE  out  1  one-cycle pulse when SEG has been updated.
REQ-011 OVF  out  N_CH  per channel: decimal value exceeds 10^N_DIG-1.
REQ-012 SEG  out  N_CH*N_DIG*7  active-low segments; channel c, digit d at [(c*N_DIG+d)*7 +: 7]; bits 0..6 = a..g; d=0 is the least significant digit.

Function
REQ-013 FSM SHALL have two states: IDLE (READY=1) and CONV (READY=0), plus a conversion counter of width ceil(log2(W+1)).
REQ-014 IDLE with LOAD=1 at edge k SHALL capture COORD and MODE into shadow registers and enter CONV; later COORD/MODE changes SHALL NOT affect the result.
REQ-015 Hex mode: CONV SHALL last one cycle; at edge k+1, digit d SHALL show nibble d (0 for d >= ceil(W/4)); OVF SHALL be 0.
REQ-016 Decimal mode: CONV SHALL run shift-add-3 (double dabble), one bit per cycle, for all channels in parallel; SEG SHALL be updated at edge k+W.
REQ-017 Decimal overflow (value > 10^N_DIG-1, detected as a carry out of the top BCD digit) SHALL set all digits of that channel to '-' (segment g only lit) and set OVF[c]=1.
REQ-018 On the update edge: SEG and OVF SHALL be written, DONE=1 for exactly one cycle, READY=1, state returns to IDLE.
REQ-019 LOAD while READY=0 SHALL be ignored (no queueing); LOAD in the cycle DONE=1 SHALL be accepted.
REQ-020 SEG SHALL hold its last value between updates.
REQ-021 Glyphs: standard 0-9 and A, b, C, d, E, F.

Reset
REQ-022 RST=1 SHALL force immediately: SEG all ones (blank), OVF=0, DONE=0, READY=1, state IDLE, counter 0, shadow registers 0.
REQ-023 RST asserted during CONV SHALL abort the conversion; no DONE SHALL follow its release.

Configuration
REQ-024 Macro SEG7_LZ_BLANK_EN defined: digits above the most significant non-zero digit SHALL be blanked (all ones); digit 0 SHALL never be blanked; overflow '-' glyphs SHALL NOT be blanked.
REQ-025 SEG7_LZ_BLANK_EN undefined: all N_DIG digits SHALL always display, leading zeros included.

Structure
REQ-026 Shared header seg7_pkg.vh SHALL hold the glyph constants (blank, dash), the FSM state encodings and the MODE encodings.
REQ-027 One combinational sub-module, seg7_digit (4-bit in, 7-bit active-low out), SHALL be instantiated N_CH*N_DIG times; the FSM, BCD shift registers and blanking logic SHALL stay in the top module.

Verification (SEG glyphs given as g..a)
REQ-028 Reset: RST=1 -> SEG all 1, READY=1, DONE=0, OVF=0, before any clock edge.
REQ-029 Hex: ch0=12'hA5F, ch1=12'h010, MODE=0, LOAD at edge k -> DONE at k+1; ch0 d0..d2 = F 0001110, 5 0010010, A 0001000; d3 = 0 1000000 (blank with LZ); ch1 d1 = 1 1111001, d0 = 0, d2/d3 blank with LZ.
REQ-030 Decimal: ch0=4095, MODE=1 -> DONE exactly 12 edges after LOAD; d0..d3 = 5, 9, 0 1000000, 4 0011001; OVF=0.
REQ-031 Overflow with N_DIG=3: decimal 1000 -> ch0 all digits 0111111, OVF[0]=1; then 999 -> 9 0010000 x3, OVF[0]=0.
REQ-032 LOAD pulses and COORD changes during CONV -> ignored, result matches the captured value; LOAD in the DONE cycle -> a second conversion starts.
REQ-033 RST during cycle 5 of a decimal CONV -> SEG blank, READY=1, no DONE after release until a new LOAD.
